main_mem_arbiter: RTL and testbench

Shares the single-port main data memory between NUM_REQ requesters: memory-access stage data port, instruction-fetch refill port, and a debug/program loader. Each cycle it selects one requester by round-robin and drives the memory chip-select, write-enable, address and write data. It routes read data back to the owning requester after the fixed memory read latency. It sits between the pipeline/loader masters and the main memory macro.

---
 rtl/main_mem_arbiter_pkg.sv | 21 ++
 rtl/main_mem_arbiter_if.sv | 35 +++
 rtl/main_mem_arbiter_rr_arbiter.sv | 63 ++++++
 rtl/main_mem_arbiter.sv | 82 ++++++++
 tb/tb_main_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/main_mem_arbiter_pkg.sv
// Shared types for the main-memory arbiter: requester indices, owner tag, read-tag record.
// Latency: n/a (types only).
// Backpressure: n/a.
package main_mem_arb_pkg;

  localparam int NUM_REQ_DEF = 3;

  // Requester slots on the shared memory port
  localparam int REQ_MA  = 0;  // memory-access stage data port
  localparam int REQ_IF  = 1;  // instruction-fetch refill
  localparam int REQ_LDR = 2;  // debug / program loader

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] owner_t;

  // One slot of the read-return tracker: is a read in flight, and who owns it
  typedef struct packed {
    logic   vld;
    owner_t own;
  } rd_tag_t;

endpackage

// File: rtl/main_mem_arbiter_if.sv
// Requester-side and memory-side bundle of the main-memory arbiter.
// Latency: n/a (wires only).
// Backpressure: grant-based on requests, none on responses.
interface main_mem_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DAT_W   = 32
);

  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ-1:0]        req_wen;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DAT_W-1:0]  req_dat;
  logic [NUM_REQ-1:0]        req_gnt;
  logic [NUM_REQ-1:0]        rsp_vld;
  logic [DAT_W-1:0]          rsp_dat;
  logic                      mem_cs;
  logic                      mem_wen;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DAT_W-1:0]          mem_dat_in;
  logic [DAT_W-1:0]          mem_dat_out;

  // Arbiter view
  modport slave (
    input  req_vld, req_wen, req_addr, req_dat, mem_dat_out,
    output req_gnt, rsp_vld, rsp_dat, mem_cs, mem_wen, mem_addr, mem_dat_in
  );

  // Requesters plus memory macro view
  modport master (
    output req_vld, req_wen, req_addr, req_dat, mem_dat_out,
    input  req_gnt, rsp_vld, rsp_dat, mem_cs, mem_wen, mem_addr, mem_dat_in
  );

endinterface

// File: rtl/main_mem_arbiter_rr_arbiter.sv
// Rotate-priority picker with registered pointer; optional MAIN_MEM_ARB_DATA_PRIO_EN gives index 0 absolute priority.
// Latency: grant combinational in the request cycle; pointer moves at the next edge.
// Backpressure: none; a requester simply waits until its grant bit is set.
module rr_arbiter
  import main_mem_arb_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int OWN_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [OWN_W-1:0]   win_o,
  output logic               any_o
);

  localparam logic [OWN_W-1:0] LAST = OWN_W'(NUM_REQ - 1);

  logic [OWN_W-1:0] ptr_q, ptr_d;

  // Pick the first requester at or after the pointer; nothing is granted while in reset
  always_comb begin
    int idx;
    idx   = 0;
    gnt_o = '0;
    win_o = '0;
    any_o = 1'b0;
`ifdef MAIN_MEM_ARB_DATA_PRIO_EN
    if (req_i[REQ_MA]) begin
      any_o = 1'b1;
      win_o = OWN_W'(REQ_MA);
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_o && req_i[idx]) begin
        any_o = 1'b1;
        win_o = OWN_W'(idx);
      end
    end
    if (rst) any_o = 1'b0;
    if (any_o) gnt_o[win_o] = 1'b1;
  end

  // Next pointer sits just past the winner, wrapping at the last index
  always_comb begin
    ptr_d = ptr_q;
`ifdef MAIN_MEM_ARB_DATA_PRIO_EN
    if (any_o && (win_o != OWN_W'(REQ_MA))) ptr_d = (win_o == LAST) ? '0 : win_o + OWN_W'(1);
`else
    if (any_o) ptr_d = (win_o == LAST) ? '0 : win_o + OWN_W'(1);
`endif
  end

  // Round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Shares the single-port main memory between NUM_REQ requesters and returns read data to the owner.
// Latency: grant and memory drive in the request cycle; read data returned exactly READ_LAT cycles later.
// Backpressure: requests wait for grant; responses cannot be stalled. Option: MAIN_MEM_ARB_DATA_PRIO_EN.
module main_mem_arbiter
  import main_mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 32,
  parameter int DAT_W    = 32,
  parameter int READ_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  main_mem_arbiter_if.slave  bus
);

  localparam int OWN_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [OWN_W-1:0]   win;
  logic               any;

  // Owner tracking: slot 0 holds the access granted last cycle, the last slot lines up with mem_dat_out
  rd_tag_t tag_q [READ_LAT];
  rd_tag_t tag_d;
  rd_tag_t head;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_i (bus.req_vld),
    .gnt_o (gnt),
    .win_o (win),
    .any_o (any)
  );

  assign bus.req_gnt = gnt;

  // Drive the memory port from the winner; quiet and zeroed when idle
  always_comb begin
    bus.mem_cs     = 1'b0;
    bus.mem_wen    = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_dat_in = '0;
    if (any) begin
      bus.mem_cs     = 1'b1;
      bus.mem_wen    = bus.req_wen[win];
      bus.mem_addr   = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
      bus.mem_dat_in = bus.req_dat[int'(win)*DAT_W +: DAT_W];
    end
  end

  // Accepted reads enter the tracker tagged with their owner; writes and idle cycles enter as bubbles
  always_comb begin
    tag_d     = '0;
    tag_d.vld = any && !bus.req_wen[win];
    tag_d.own = owner_t'(win);
  end

  // Shift the owner tracker; reset drops every in-flight read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < READ_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign head = tag_q[READ_LAT-1];

  // Steer returning memory data to the owner of the oldest tracked read
  always_comb begin
    bus.rsp_vld = '0;
    bus.rsp_dat = '0;
    if (head.vld && !rst) begin
      bus.rsp_vld[head.own] = 1'b1;
      bus.rsp_dat           = bus.mem_dat_out;
    end
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed plus random checks of main_mem_arbiter against a queue-based reference model.
// Latency: model expects grant in-cycle and read data READ_LAT cycles after the grant edge.
// Backpressure: requesters hold their request until granted.
module tb_main_mem_arbiter;
  import main_mem_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  main_mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DAT_W(DW)) bus ();

  main_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DAT_W(DW), .READ_LAT(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory macro stand-in: synchronous write, READ_LAT-cycle read
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  logic [DW-1:0] rd_line [RL];
  always @(posedge clk) begin
    for (int i = RL-1; i > 0; i--) rd_line[i] <= rd_line[i-1];
    if (bus.mem_cs && !bus.mem_wen)
      rd_line[0] <= mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : '0;
    if (bus.mem_cs && bus.mem_wen) mem_arr[bus.mem_addr] = bus.mem_dat_in;
  end
  assign bus.mem_dat_out = rd_line[RL-1];

  // Requester state
  logic [N-1:0]  r_vld, r_wen;
  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_dat  [N];

  // Reference model state
  typedef struct { int due; int own; logic [DW-1:0] d; } exp_rsp_t;
  logic [DW-1:0] m_mem [logic [AW-1:0]];
  exp_rsp_t exp_q [$];
  int m_ptr, cyc, last_w, prev_w;
  int waitc [N];
  bit rnd_mode;
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.req_vld = r_vld;
    bus.req_wen = r_wen;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW] = r_addr[i];
      bus.req_dat[i*DW +: DW]  = r_dat[i];
    end
  endtask

  function automatic int model_pick();
`ifdef MAIN_MEM_ARB_DATA_PRIO_EN
    if (r_vld[REQ_MA]) return REQ_MA;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (r_vld[i]) return i;
    end
    return -1;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_arr[a] = d;
    m_mem[a]   = d;
  endtask

  task automatic enter_reset();
    rst   = 1'b1;
    m_ptr = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) waitc[i] = 0;
    apply();
  endtask

  // One clock spent in reset, all outputs must be quiet
  task automatic check_rst(input string tag);
    apply();
    @(negedge clk);
    check({tag, ".gnt"},  64'(bus.req_gnt),    64'(0));
    check({tag, ".rsp"},  64'(bus.rsp_vld),    64'(0));
    check({tag, ".cs"},   64'(bus.mem_cs),     64'(0));
    check({tag, ".wen"},  64'(bus.mem_wen),    64'(0));
    check({tag, ".addr"}, 64'(bus.mem_addr),   64'(0));
    check({tag, ".din"},  64'(bus.mem_dat_in), 64'(0));
    check({tag, ".rdat"}, 64'(bus.rsp_dat),    64'(0));
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // One normal cycle: predict, compare at the falling edge, then advance the model at the rising edge
  task automatic do_cycle(input string tag);
    int w;
    logic [N-1:0]  eg, er;
    logic [DW-1:0] ed;
    exp_rsp_t      e;
    apply();
    w  = model_pick();
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    er = '0;
    ed = '0;
    foreach (exp_q[k]) if (exp_q[k].due == cyc) begin
      er[exp_q[k].own] = 1'b1;
      ed               = exp_q[k].d;
    end
    @(negedge clk);
    check({tag, ".gnt"},  64'(bus.req_gnt),    64'(eg));
    check({tag, ".cs"},   64'(bus.mem_cs),     64'(w >= 0));
    check({tag, ".wen"},  64'(bus.mem_wen),    64'((w >= 0) ? r_wen[w]  : 1'b0));
    check({tag, ".addr"}, 64'(bus.mem_addr),   64'((w >= 0) ? r_addr[w] : '0));
    check({tag, ".din"},  64'(bus.mem_dat_in), 64'((w >= 0) ? r_dat[w]  : '0));
    check({tag, ".rsp"},  64'(bus.rsp_vld),    64'(er));
    if (er != '0) check({tag, ".rdat"}, 64'(bus.rsp_dat), 64'(ed));
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++) if (r_vld[i] && i != w) waitc[i]++;
    if (w >= 0) begin
      if (r_wen[w]) m_mem[r_addr[w]] = r_dat[w];
      else begin
        e.due = cyc - 1 + RL;
        e.own = w;
        e.d   = m_mem.exists(r_addr[w]) ? m_mem[r_addr[w]] : '0;
        exp_q.push_back(e);
      end
`ifdef MAIN_MEM_ARB_DATA_PRIO_EN
      if (w != REQ_MA) m_ptr = (w + 1) % N;
`else
      m_ptr = (w + 1) % N;
      check({tag, ".starve"}, 64'(waitc[w] < N), 64'(1));
`endif
      waitc[w] = 0;
      r_vld[w] = 1'b0;
    end
    last_w = w;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
    if (rnd_mode) begin
      for (int i = 0; i < N; i++) if (!r_vld[i] && $urandom_range(0, 1) == 1) begin
        r_vld[i]  = 1'b1;
        r_wen[i]  = ($urandom_range(0, 2) == 0);
        r_addr[i] = AW'($urandom_range(0, 15) * 4);
        r_dat[i]  = DW'($urandom);
      end
    end
    #1;
  endtask

  initial begin
    r_vld    = '0;
    r_wen    = '0;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = AW'(i * 4);
      r_dat[i]  = '0;
      waitc[i]  = 0;
    end
    cyc      = 0;
    m_ptr    = 0;
    last_w   = -1;
    prev_w   = -1;
    rnd_mode = 1'b0;
    preload(32'h40, 32'hDEADBEEF);
    #1;

    // Reset with everyone requesting: outputs stay quiet
    r_vld = '1;
    enter_reset();
    check_rst("rst0");
    check_rst("rst1");
    r_vld = '0;
    rst   = 1'b0;

    // Single read from the MA port
    r_vld[REQ_MA] = 1'b1; r_wen[REQ_MA] = 1'b0; r_addr[REQ_MA] = 32'h40;
    do_cycle("rd1");
    check("rd1.win", 64'(last_w), 64'(REQ_MA));
    do_cycle("rd1.ret");

    // All requesting continuously from reset
    enter_reset();
    check_rst("rst2");
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      r_vld = '1;
      r_wen = '0;
      do_cycle("all");
`ifndef MAIN_MEM_ARB_DATA_PRIO_EN
      check("all.seq", 64'(last_w), 64'(k % N));
`else
      check("all.prio", 64'(last_w), 64'(REQ_MA));
`endif
    end
    r_vld = '0;
    do_cycle("all.drain");
    do_cycle("all.drain2");

    // Write from IF refill, then read back through the loader
    r_vld[REQ_IF] = 1'b1; r_wen[REQ_IF] = 1'b1; r_addr[REQ_IF] = 32'h10; r_dat[REQ_IF] = 32'h55AA;
    do_cycle("wr");
    check("wr.win", 64'(last_w), 64'(REQ_IF));
    r_vld[REQ_LDR] = 1'b1; r_wen[REQ_LDR] = 1'b0; r_addr[REQ_LDR] = 32'h10;
    do_cycle("rd2");
    check("rd2.win", 64'(last_w), 64'(REQ_LDR));
    do_cycle("rd2.ret");

    // Pointer wrap: ptr=2 with idx0 and idx2 requesting
    enter_reset();
    check_rst("rst3");
    rst = 1'b0;
    r_vld[REQ_IF] = 1'b1; r_wen[REQ_IF] = 1'b0;
    do_cycle("wrap.pre");
    r_vld = 3'b101; r_wen = '0;
    do_cycle("wrap.a");
`ifndef MAIN_MEM_ARB_DATA_PRIO_EN
    check("wrap.a.win", 64'(last_w), 64'(2));
`else
    check("wrap.a.win", 64'(last_w), 64'(0));
`endif
    do_cycle("wrap.b");
`ifndef MAIN_MEM_ARB_DATA_PRIO_EN
    check("wrap.b.win", 64'(last_w), 64'(0));
`else
    check("wrap.b.win", 64'(last_w), 64'(2));
`endif
    do_cycle("wrap.ret");

    // Reset while a read is in flight
    r_vld = 3'b010; r_wen = '0; r_addr[REQ_IF] = 32'h40;
    do_cycle("mid.gnt");
    r_vld = 3'b101; r_addr[REQ_MA] = 32'h40; r_addr[REQ_LDR] = 32'h10;
    enter_reset();
    check_rst("mid.rst0");
    check_rst("mid.rst1");
    rst = 1'b0;
    do_cycle("mid.post");
    check("mid.post.win", 64'(last_w), 64'(REQ_MA));
    do_cycle("mid.ret");
    do_cycle("mid.drain");

`ifdef MAIN_MEM_ARB_DATA_PRIO_EN
    // Data port dominates while asserted, then the others alternate
    for (int k = 0; k < 4; k++) begin
      r_vld = '1; r_wen = '0;
      do_cycle("prio.ma");
      check("prio.ma.win", 64'(last_w), 64'(REQ_MA));
    end
    prev_w = -1;
    for (int k = 0; k < 4; k++) begin
      r_vld = 3'b110;
      do_cycle("prio.alt");
      if (prev_w > 0) check("prio.alt.win", 64'(last_w), 64'((prev_w == 1) ? 2 : 1));
      prev_w = last_w;
    end
    r_vld = '0;
    do_cycle("prio.drain");
`endif

    // Random traffic with occasional reset
    r_vld    = '0;
    rnd_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 50) begin
        enter_reset();
        check_rst("rnd.rst");
        rst = 1'b0;
      end
      do_cycle("rnd");
    end
    rnd_mode = 1'b0;
    r_vld    = '0;
    for (int n = 0; n < 2 * N; n++) do_cycle("end.drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
